// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: round-robin arbiter sharing one register-file write port
// among NREQ writeback requesters, with a registered write output, a
// per-register write-protect mask and an exclusive-lock mode for requester 0.
// Optional macro WB_BYPASS_EN adds two combinational read-bypass ports that
// forward the write being committed this cycle.
module regfile_wr_arbiter #(
  parameter int unsigned NREQ         = 3,
  parameter logic [15:0] PROTECT_MASK = 16'h5C00
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [4*NREQ-1:0]    req_dst,
  input  logic [24*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 lock_req,
  output logic                 locked,
  output logic                 rf_we,
  output logic [3:0]           rf_dst,
  output logic [23:0]          rf_data,
  output logic [1:0]           grant_id,
  output logic                 prot_err,
`ifdef WB_BYPASS_EN
  input  logic [3:0]           rd_src0,
  input  logic [3:0]           rd_src1,
  input  logic [23:0]          rf_rdata0,
  input  logic [23:0]          rf_rdata1,
  output logic [23:0]          byp_data0,
  output logic [23:0]          byp_data1,
`endif
  input  logic                 prot_err_clr
);

  localparam int unsigned PTR_W  = 2;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned DST_W  = 4;
  localparam int unsigned DATA_W = 24;

  localparam logic [0:0] ST_ARB  = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

  logic [0:0]       r_state;
  logic [0:0]       w_state_nxt;
  logic [PTR_W-1:0] r_rr_ptr;

  logic [NREQ-1:0]   w_ready;
  logic              w_found;
  logic [PTR_W-1:0]  w_gnt_idx;
  logic [IDX_W-1:0]  w_idx;
  logic [DST_W-1:0]  w_dst;
  logic [DATA_W-1:0] w_data;
  logic              w_prot;

  // State register: lock mode is dropped on reset
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_ARB;
    else        r_state <= w_state_nxt;
  end

  // Next state: lock follows lock_req at every edge
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ARB:  if (lock_req)  w_state_nxt = ST_LOCK;
      ST_LOCK: if (!lock_req) w_state_nxt = ST_ARB;
      default: w_state_nxt = ST_ARB;
    endcase
  end

  // Grant selection: round robin from rr_ptr, or requester 0 only when locked
  always_comb begin
    w_ready   = '0;
    w_found   = 1'b0;
    w_gnt_idx = '0;
    w_idx     = '0;
    if (rst_n) begin
      if (r_state == ST_LOCK) begin
        w_ready[0] = req_valid[0];
        w_found    = req_valid[0];
      end else begin
        for (int unsigned k = 0; k < NREQ; k++) begin
          w_idx = IDX_W'(r_rr_ptr) + IDX_W'(k);
          if (w_idx >= IDX_W'(NREQ)) w_idx = w_idx - IDX_W'(NREQ);
          if (!w_found && req_valid[w_idx[PTR_W-1:0]]) begin
            w_found                    = 1'b1;
            w_gnt_idx                  = w_idx[PTR_W-1:0];
            w_ready[w_idx[PTR_W-1:0]]  = 1'b1;
          end
        end
      end
    end
  end

  assign req_ready = w_ready;
  assign locked    = (r_state == ST_LOCK);

  // Payload mux for the granted requester
  always_comb begin
    w_dst  = '0;
    w_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_gnt_idx == PTR_W'(i)) begin
        w_dst  = req_dst[DST_W*i +: DST_W];
        w_data = req_data[DATA_W*i +: DATA_W];
      end
    end
  end

  assign w_prot = PROTECT_MASK[w_dst];

  // Registered write port; protected writes are dropped but still handshake
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_dst   <= '0;
      rf_data  <= '0;
      grant_id <= '0;
    end else begin
      rf_we <= w_found && !w_prot;
      if (w_found && !w_prot) begin
        rf_dst   <= w_dst;
        rf_data  <= w_data;
        grant_id <= w_gnt_idx;
      end
    end
  end

  // Sticky protect error; a new violation beats the clear
  always_ff @(posedge clk) begin
    if (!rst_n)                 prot_err <= 1'b0;
    else if (w_found && w_prot) prot_err <= 1'b1;
    else if (prot_err_clr)      prot_err <= 1'b0;
  end

  // Round-robin pointer: advances past the grantee in ARB, frozen in LOCK
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
    end else if (w_found && r_state == ST_ARB) begin
      if (w_gnt_idx == PTR_W'(NREQ - 1)) r_rr_ptr <= '0;
      else                               r_rr_ptr <= w_gnt_idx + PTR_W'(1);
    end
  end

`ifdef WB_BYPASS_EN
  // Same-cycle forwarding of the write being committed
  assign byp_data0 = (rf_we && rf_dst == rd_src0) ? rf_data : rf_rdata0;
  assign byp_data1 = (rf_we && rf_dst == rd_src1) ? rf_data : rf_rdata1;
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb_regfile_wr_arbiter: directed-vector bench for regfile_wr_arbiter (NREQ=3).
module tb_regfile_wr_arbiter;

  localparam int unsigned NREQ = 3;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [4*NREQ-1:0] req_dst;
  logic [24*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              lock_req;
  logic              locked;
  logic              rf_we;
  logic [3:0]        rf_dst;
  logic [23:0]       rf_data;
  logic [1:0]        grant_id;
  logic              prot_err;
  logic              prot_err_clr;
`ifdef WB_BYPASS_EN
  logic [3:0]  rd_src0, rd_src1;
  logic [23:0] rf_rdata0, rf_rdata1, byp_data0, byp_data1;
`endif

  int n_checks = 0;
  int n_errors = 0;

  regfile_wr_arbiter #(.NREQ(NREQ), .PROTECT_MASK(16'h5C00)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_dst      (req_dst),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .lock_req     (lock_req),
    .locked       (locked),
    .rf_we        (rf_we),
    .rf_dst       (rf_dst),
    .rf_data      (rf_data),
    .grant_id     (grant_id),
    .prot_err     (prot_err),
`ifdef WB_BYPASS_EN
    .rd_src0      (rd_src0),
    .rd_src1      (rd_src1),
    .rf_rdata0    (rf_rdata0),
    .rf_rdata1    (rf_rdata1),
    .byp_data0    (byp_data0),
    .byp_data1    (byp_data1),
`endif
    .prot_err_clr (prot_err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after posedge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after an input change
  task automatic settle();
    #1;
  endtask

  task automatic set_req(input int i, input logic [3:0] dst, input logic [23:0] data);
    req_dst[4*i +: 4]   = dst;
    req_data[24*i +: 24] = data;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; req_dst = '0; req_data = '0;
    lock_req = 1'b0; prot_err_clr = 1'b0;
`ifdef WB_BYPASS_EN
    rd_src0 = '0; rd_src1 = '0; rf_rdata0 = '0; rf_rdata1 = '0;
`endif

    // Reset: ready forced low even with all requesters valid
    req_valid = 3'b111;
    tick(); tick();
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_we", 32'(rf_we), 32'h0);
    check("rst_locked", 32'(locked), 32'h0);
    check("rst_prot", 32'(prot_err), 32'h0);
    check("rst_dst", 32'(rf_dst), 32'h0);
    check("rst_gid", 32'(grant_id), 32'h0);
    req_valid = '0;
    rst_n = 1'b1;

    // Idle after reset
    for (int c = 0; c < 3; c++) begin
      tick();
      check("idle_we", 32'(rf_we), 32'h0);
      check("idle_ready", 32'(req_ready), 32'h0);
      check("idle_locked", 32'(locked), 32'h0);
    end

    // Single requester 1
    set_req(1, 4'd6, 24'h000009);
    req_valid = 3'b010;
    settle();
    check("single_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = 3'b111;
    settle();
    check("single_we", 32'(rf_we), 32'h1);
    check("single_dst", 32'(rf_dst), 32'h6);
    check("single_data", 32'(rf_data), 32'h9);
    check("single_gid", 32'(grant_id), 32'h1);
    check("single_ptr2", 32'(req_ready), 32'h4);
    req_valid = '0;

    // Round robin from a fresh reset with everyone valid
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) set_req(i, 4'(i + 1), 24'(24'h000100 + i));
    req_valid = 3'b111;
    for (int n = 0; n < 6; n++) begin
      settle();
      check("rr_ready", 32'(req_ready), 32'(1 << (n % 3)));
      tick();
      check("rr_we", 32'(rf_we), 32'h1);
      check("rr_gid", 32'(grant_id), 32'(n % 3));
      check("rr_dst", 32'(rf_dst), 32'((n % 3) + 1));
      check("rr_data", 32'(rf_data), 32'(24'h000100 + (n % 3)));
    end
    req_valid = '0;
    tick();
    check("rr_idle_we", 32'(rf_we), 32'h0);
    check("rr_hold_dst", 32'(rf_dst), 32'h3);
    check("rr_hold_gid", 32'(grant_id), 32'h2);

    // Lock: pointer moved to 2 first
    req_valid = 3'b010;
    settle();
    check("lk_pre_ready", 32'(req_ready), 32'h2);
    tick();
    // Transition cycle still arbitrates round robin
    lock_req = 1'b1;
    settle();
    check("lk_trans_ready", 32'(req_ready), 32'h2);
    tick();
    check("lk_locked", 32'(locked), 32'h1);
    check("lk_trans_gid", 32'(grant_id), 32'h1);
    req_valid = 3'b111;
    settle();
    check("lk_ready0", 32'(req_ready), 32'h1);
    tick();
    check("lk_we0", 32'(rf_we), 32'h1);
    check("lk_gid0", 32'(grant_id), 32'h0);
    req_valid = 3'b110;
    settle();
    check("lk_ready_none", 32'(req_ready), 32'h0);
    tick();
    check("lk_we_none", 32'(rf_we), 32'h0);
    lock_req = 1'b0;
    req_valid = '0;
    tick();
    check("lk_released", 32'(locked), 32'h0);
    req_valid = 3'b111;
    settle();
    check("lk_frozen_ptr", 32'(req_ready), 32'h4);
    tick();
    check("lk_resume_gid", 32'(grant_id), 32'h2);
    req_valid = '0;

    // Write protect: ptr is now 0
    set_req(0, 4'd11, 24'h00BEEF);
    req_valid = 3'b001;
    settle();
    check("wp_ready", 32'(req_ready), 32'h1);
    tick();
    check("wp_we", 32'(rf_we), 32'h0);
    check("wp_err", 32'(prot_err), 32'h1);
    check("wp_hold_dst", 32'(rf_dst), 32'h3);
    set_req(0, 4'd14, 24'h00CAFE);
    prot_err_clr = 1'b1;
    tick();
    check("wp_set_wins", 32'(prot_err), 32'h1);
    check("wp_we2", 32'(rf_we), 32'h0);
    req_valid = '0;
    tick();
    check("wp_cleared", 32'(prot_err), 32'h0);
    prot_err_clr = 1'b0;
    req_valid = 3'b111;
    settle();
    check("wp_ptr_adv", 32'(req_ready), 32'h2);
    req_valid = '0;

    // Reset mid-operation drops lock and any pending write
    lock_req = 1'b1;
    tick();
    check("mid_locked", 32'(locked), 32'h1);
    set_req(0, 4'd2, 24'h000777);
    req_valid = 3'b001;
    rst_n = 1'b0;
    settle();
    check("mid_rst_ready", 32'(req_ready), 32'h0);
    tick();
    check("mid_rst_we", 32'(rf_we), 32'h0);
    check("mid_rst_locked", 32'(locked), 32'h0);
    rst_n = 1'b1;
    lock_req = 1'b0;
    req_valid = '0;
    tick();

`ifdef WB_BYPASS_EN
    // Bypass of the write being committed
    set_req(1, 4'd7, 24'h00ABCD);
    req_valid = 3'b010;
    tick();
    req_valid = '0;
    rd_src0 = 4'd7; rd_src1 = 4'd8;
    rf_rdata0 = 24'h111111; rf_rdata1 = 24'h222222;
    settle();
    check("byp0", 32'(byp_data0), 32'h00ABCD);
    check("byp1", 32'(byp_data1), 32'h222222);
    tick();
    check("byp0_idle", 32'(byp_data0), 32'h111111);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
- Shares the single register-file write port (we/dst/data, 16 x 24-bit) among NREQ writeback requesters, e.g. ALU writeback, memory-load writeback and host/debug loader.
- Round-robin arbitration with a valid/ready handshake per requester.
- Registered write output, per-register write-protect mask, and an exclusive-lock mode for requester 0 (host).
- Sits between the execution units and the register file.

Parameters:
- NREQ, 3, number of requesters (2..4); index 0 is the host/lock-capable requester.
- PROTECT_MASK, 16'h5C00, bit r=1 means register r is write-protected (answer/end constants 10,11,12,14).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  NREQ  per-requester write request.
- req_dst  in  4*NREQ  destination register, requester i in bits [4i+3:4i].
- req_data  in  24*NREQ  write data, requester i in bits [24i+23:24i].
- req_ready  out  NREQ  one-hot grant; handshake completes when valid&ready.
- lock_req  in  1  requester 0 asks for exclusive write access.
- locked  out  1  arbiter is in LOCK state.
- rf_we  out  1  register-file write enable.
- rf_dst  out  4  register-file write address.
- rf_data  out  24  register-file write data.
- grant_id  out  2  index of the requester that produced the current rf_* write.
- prot_err  out  1  sticky flag: a write to a protected register was dropped.
- prot_err_clr  in  1  clears prot_err.

Behaviour:
- Reset (rst_n=0 at posedge clk): rf_we=0, rf_dst=0, rf_data=0, grant_id=0, prot_err=0, locked=0, state=ARB, rr_ptr=0. req_ready is forced to 0 while rst_n=0.
- req_ready is combinational from req_valid, state and rr_ptr.
  - At most one bit is set.
  - A bit is never set without the matching req_valid.
- Requesters hold valid/dst/data stable until ready. Dropping valid before ready is legal; that request is simply withdrawn.
- Write latency is 1 cycle. A handshake in cycle N produces rf_we=1 with the captured dst/data/grant_id in cycle N+1.
  - rf_we is 0 in every cycle not preceded by a handshake.
  - rf_dst, rf_data and grant_id hold their last value when rf_we=0.
- ARB state (round robin):
  - Search starts at rr_ptr, ascending with wrap modulo NREQ. The first valid requester is granted.
  - After a grant to i, rr_ptr <= (i+1) mod NREQ.
  - With no valid requester, rr_ptr is unchanged.
- LOCK state:
  - Only requester 0 may be granted; req_ready[i>0]=0.
  - rr_ptr is frozen.
- Transitions:
  - ARB->LOCK at the posedge where lock_req=1. The grant in that same cycle still follows ARB rules.
  - LOCK->ARB at the posedge where lock_req=0.
  - locked reflects the state register.
- Write protect:
  - A handshake whose dst has PROTECT_MASK[dst]=1 completes normally (ready asserted, requester released).
  - rf_we stays 0 in the following cycle.
  - prot_err <= 1 at that edge.
  - rr_ptr advances as for a normal grant.
- prot_err_clr=1 clears prot_err. If a new protect violation occurs in the same cycle, set wins.
- Same dst from consecutive grants: writes are issued in grant order, and the last one wins in the register file.
- Reset mid-operation: a captured but not yet issued write is discarded (rf_we=0 after reset). The lock state is dropped.
- Out-of-range values: any bit of req_valid at index >= NREQ does not exist. grant_id is zero-extended to 2 bits.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined, the block adds:
  - Inputs rd_src0 and rd_src1 (4 bits each).
  - Inputs rf_rdata0 and rf_rdata1 (24 bits each).
  - Outputs byp_data0 and byp_data1 (24 bits each).
- Bypass rule for port k:
  - If rf_we=1 and rf_dst==rd_srck, byp_datak=rf_data.
  - Otherwise byp_datak=rf_rdatak.
  - This is combinational and gives same-cycle forwarding of the write being committed.
- Not defined: these ports are absent and there is no extra logic.

Test Plan:
- Reset and idle: rst_n=0 for 2 cycles, then all req_valid=0 -> rf_we=0, req_ready=0, locked=0, prot_err=0 in every cycle.
- Single requester: req 1 valid with dst=6, data=24'h000009 -> req_ready=3'b010 same cycle; next cycle rf_we=1, rf_dst=6, rf_data=9, grant_id=1; rr_ptr becomes 2.
- Round-robin fairness: all 3 requesters valid continuously from reset -> grant order 0,1,2,0,1,2; each write appears one cycle after its grant; no requester is skipped.
- Lock mode: lock_req=1 with reqs 1 and 2 valid -> after the transition edge only requester 0 is granted; req 1 and req 2 ready stay 0; after lock_req=0, grants resume at the frozen rr_ptr.
- Write protect: req 0 writes dst=11 -> ready=1, no rf_we next cycle, prot_err=1; then prot_err_clr=1 together with a new write to dst=14 -> prot_err stays 1.
- Bypass (WB_BYPASS_EN defined): write dst=7, data=24'h00ABCD committing while rd_src0=7 and rd_src1=8 -> byp_data0=24'h00ABCD and byp_data1=rf_rdata1.
